// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter_pkg
// Purpose : Shared types and constants for the writeback arbiter slice.
//           Register-address width, data width, default load-buffer depth,
//           arbitration state encoding, the buffered-beat record and a
//           destination decoder used to build the hazard busy mask.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int DATA_W        = 32;
    localparam int WB_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        WB_ST_NORMAL = 1'b0,
        WB_ST_DRAIN  = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_beat_t;

    // One-hot decode of a destination; r0 is hardwired so it never reads busy.
    function automatic logic [31:0] dest_decode(input logic [REG_ADDR_W-1:0] dest);
        logic [31:0] onehot;
        onehot       = '0;
        onehot[dest] = 1'b1;
        onehot[0]    = 1'b0;
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_load_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_load_fifo
// Purpose : Small circular buffer holding load results waiting for the
//           register-file write port. Pointers wrap modulo DEPTH; occupancy
//           is kept in a separate counter so full and empty are unambiguous.
//           A push is accepted while full only if a pop happens in the same
//           cycle. Per-entry valid and dest taps feed the busy mask.
// Ports   : clk, rst            clock / synchronous active-high reset
//           push, push_beat     write request and beat
//           pop, head_beat      read request and oldest beat
//           full, empty         occupancy flags
//           entry_valid/dest    per-slot taps
// Revision: 1.0 - initial release
// ============================================================================
module wb_load_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  wb_beat_t                          push_beat,
    input  logic                              pop,
    output wb_beat_t                          head_beat,
    output logic                              full,
    output logic                              empty,
    output logic [DEPTH-1:0]                  entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]  entry_dest
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    wb_beat_t         mem_q [DEPTH];
    wb_beat_t         mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_beat = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        mem_d    = mem_q;
        // Clear before set: when full, push and pop hit the same slot.
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            mem_d[wr_ptr_q]   = push_beat;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

    assign entry_valid = valid_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_taps
        assign entry_dest[gi] = mem_q[gi].dest;
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Purpose : Writeback stage merging ALU and load results onto the single
//           register-file write port. ALU beats win; loads wait in
//           wb_load_fifo. A starvation counter forces a one-cycle drain
//           (ALU stalled) after STARVE_LIMIT consecutive ALU wins over a
//           non-empty buffer. Exports a busy mask of buffered load dests.
// Config  : WB_LOAD_BYPASS_EN - when defined, a load arriving with the buffer
//           empty, no ALU beat and state NORMAL is written directly
//           (one-cycle load latency) instead of being buffered.
// Ports   : clk, rst                         clock / sync active-high reset
//           alu_valid/dest/data, alu_stall   ALU source
//           mem_valid/dest/data, mem_ready   load source (valid/ready)
//           wb_en/dest/data                  registered register-file write
//           busy_mask                        regs with loads buffered
// Revision: 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LOAD_FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_stall,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0]     wb_data,
    output logic [31:0]           busy_mask
);

    localparam int                STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);

    wb_state_e             state_q, state_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  wb_en_q, wb_en_d;
    logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    wb_beat_t              fifo_head;
    logic [LOAD_FIFO_DEPTH-1:0]                 entry_valid;
    logic [LOAD_FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_dest;

    logic                  sel_valid;
    wb_beat_t              sel_beat;
    logic                  load_bypass;

    wb_load_fifo #(
        .DEPTH (LOAD_FIFO_DEPTH)
    ) u_load_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_beat   ({mem_dest, mem_data}),
        .pop         (fifo_pop),
        .head_beat   (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_dest  (entry_dest)
    );

    assign alu_stall = (state_q == WB_ST_DRAIN);
    assign mem_ready = !fifo_full;
    // A bypassed load is written directly, so it must not also be buffered.
    assign fifo_push = mem_valid && mem_ready && !load_bypass;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        fifo_pop    = 1'b0;
        sel_valid   = 1'b0;
        sel_beat    = '0;
        load_bypass = 1'b0;
        case (state_q)
            WB_ST_NORMAL: begin
                if (alu_valid) begin
                    sel_valid = 1'b1;
                    sel_beat  = {alu_dest, alu_data};
                    if (fifo_empty) begin
                        starve_d = '0;
                    end else if (starve_q == STARVE_MAX) begin
                        // This cycle still goes to the ALU; the drain follows.
                        state_d  = WB_ST_DRAIN;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    sel_valid = 1'b1;
                    sel_beat  = fifo_head;
                    starve_d  = '0;
                end else begin
                    starve_d = '0;
`ifdef WB_LOAD_BYPASS_EN
                    if (mem_valid) begin
                        load_bypass = 1'b1;
                        sel_valid   = 1'b1;
                        sel_beat    = {mem_dest, mem_data};
                    end
`endif
                end
            end
            WB_ST_DRAIN: begin
                fifo_pop  = !fifo_empty;
                sel_valid = !fifo_empty;
                sel_beat  = fifo_head;
                starve_d  = '0;
                state_d   = WB_ST_NORMAL;
            end
            default: state_d = WB_ST_NORMAL;
        endcase

        // r0 writes are consumed but never reach the register file.
        wb_en_d   = sel_valid && (sel_beat.dest != '0);
        wb_dest_d = sel_valid ? sel_beat.dest : wb_dest_q;
        wb_data_d = sel_valid ? sel_beat.data : wb_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WB_ST_NORMAL;
            starve_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            wb_en_q   <= wb_en_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_dest = wb_dest_q;
    assign wb_data = wb_data_q;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < LOAD_FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                busy_mask = busy_mask | dest_decode(entry_dest[i]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter
// Purpose : Scoreboard bench for wb_arbiter. A driver applies directed and
//           random beats, advances a queue-based reference model of the
//           writeback rules and pushes expected per-cycle status and
//           expected register-file writes; a monitor pops and compares on
//           every falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_dest, mem_dest;
    logic [31:0] alu_data, mem_data;
    logic        alu_stall, mem_ready, wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data, busy_mask;

    wb_arbiter #(
        .LOAD_FIFO_DEPTH (DEPTH),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_dest  (alu_dest),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_dest  (mem_dest),
        .mem_data  (mem_data),
        .wb_en     (wb_en),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [4:0] dest; logic [31:0] data; } wr_t;
    typedef struct { logic stall; logic ready; logic [31:0] busy; } st_t;
    typedef struct { logic [4:0] dest; logic [31:0] data; } ld_t;

    wr_t wq[$];
    st_t sq[$];
    ld_t fq[$];      // model of buffered loads, oldest first
    int  starve;     // consecutive ALU wins over a non-empty buffer
    bit  drain;      // next cycle is a forced drain
    bit  alu_hold, mem_hold;
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 1'b0;
    bit  done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // One clock of stimulus plus the reference model's reaction to it.
    task automatic step(input bit r,
                        input bit wav, input logic [4:0] wad, input logic [31:0] wadat,
                        input bit wmv, input logic [4:0] wmd, input logic [31:0] wmdat);
        st_t         s;
        wr_t         w;
        ld_t         b;
        bit          sel, ready, push;
        logic [31:0] busy;
        @(posedge clk);
        #1;
        busy = '0;
        foreach (fq[i]) busy[fq[i].dest] = 1'b1;
        busy[0] = 1'b0;
        ready   = (fq.size() < DEPTH);
        s.stall = drain;
        s.ready = ready;
        s.busy  = busy;
        sq.push_back(s);
        if (r) begin
            rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
            alu_hold = 1'b0; mem_hold = 1'b0;
            fq.delete(); drain = 1'b0; starve = 0;
            return;
        end
        rst = 1'b0;
        if (!alu_hold) begin alu_valid = wav; alu_dest = wad; alu_data = wadat; end
        if (!mem_hold) begin mem_valid = wmv; mem_dest = wmd; mem_data = wmdat; end
        sel  = 1'b0;
        b    = '{dest: 5'd0, data: 32'd0};
        push = mem_valid && ready;
        if (drain) begin
            b = fq.pop_front(); sel = 1'b1;
            drain = 1'b0; starve = 0;
            alu_hold = alu_valid;
        end else if (alu_valid) begin
            b = '{dest: alu_dest, data: alu_data}; sel = 1'b1;
            alu_hold = 1'b0;
            if (fq.size() == 0) starve = 0;
            else if (starve == LIMIT - 1) begin drain = 1'b1; starve = 0; end
            else starve++;
        end else begin
            alu_hold = 1'b0; starve = 0;
            if (fq.size() > 0) begin
                b = fq.pop_front(); sel = 1'b1;
            end
`ifdef WB_LOAD_BYPASS_EN
            else if (mem_valid) begin
                b = '{dest: mem_dest, data: mem_data}; sel = 1'b1; push = 1'b0;
            end
`endif
        end
        if (push) fq.push_back('{dest: mem_dest, data: mem_data});
        mem_hold = mem_valid && !ready;
        if (sel && b.dest != 5'd0) begin
            w.cyc = cyc + 1; w.dest = b.dest; w.data = b.data;
            wq.push_back(w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every falling edge consumes one status and one write slot.
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sq.size() > 0) begin
                    s = sq.pop_front();
                    checks++;
                    if (alu_stall !== s.stall || mem_ready !== s.ready || busy_mask !== s.busy) begin
                        errors++;
                        $display("FAIL status cyc=%0d: got stall=%b ready=%b busy=%h, want stall=%b ready=%b busy=%h",
                                 cyc, alu_stall, mem_ready, busy_mask, s.stall, s.ready, s.busy);
                    end
                end
                checks++;
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    w = wq.pop_front();
                    if (wb_en !== 1'b1 || wb_dest !== w.dest || wb_data !== w.data) begin
                        errors++;
                        $display("FAIL write cyc=%0d: got en=%b dest=%0d data=%h, want en=1 dest=%0d data=%h",
                                 cyc, wb_en, wb_dest, wb_data, w.dest, w.data);
                    end
                end else if (wb_en !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_write cyc=%0d: got en=%b dest=%0d data=%h, want en=0",
                             cyc, wb_en, wb_dest, wb_data);
                end
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL timeout: got no completion, want completion before 200000");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
        alu_hold = 1'b0; mem_hold = 1'b0; drain = 1'b0; starve = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b0 || wb_dest !== 5'd0 || wb_data !== 32'd0 ||
            alu_stall !== 1'b0 || mem_ready !== 1'b1 || busy_mask !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got en=%b dest=%0d data=%h stall=%b ready=%b busy=%h, want all 0 except ready=1",
                     wb_en, wb_dest, wb_data, alu_stall, mem_ready, busy_mask);
        end
        mon_en = 1'b1;

        // Single ALU write.
        step(0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
        idle(3);

        // Fill the buffer behind a continuous ALU stream, then let it drain.
        for (int i = 1; i <= 5; i++)
            step(0, 1, 5'd20, 32'hA000_0000 + i, i <= 4, 5'(i), 32'h1000 + i);
        idle(8);

        // Starvation: one buffered load vs. a continuous ALU stream.
        step(0, 1, 5'd6, 32'hB000_0000, 1, 5'd5, 32'h5555_5555);
        for (int i = 1; i <= 12; i++) step(0, 1, 5'd6, 32'hB000_0000 + i, 0, 0, 0);
        idle(3);

        // Destination r0 from both sources.
        step(0, 1, 5'd0, 32'h0BAD_0000, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd0, 32'h0BAD_0001);
        idle(3);

        // Reset with three buffered loads.
        for (int i = 0; i < 3; i++)
            step(0, 1, 5'd9, 32'hC000_0000 + i, 1, 5'(11 + i), 32'hD000_0000 + i);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(6);

        // Lone load into an empty buffer (bypass-dependent latency).
        step(0, 0, 0, 0, 1, 5'd7, 32'h12345678);
        idle(3);

        // Randomized traffic with rare resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(199) == 0),
                 ($urandom_range(9) < 6), 5'($urandom_range(31)), $urandom,
                 ($urandom_range(1) == 1), 5'($urandom_range(31)), $urandom);
        end
        idle(12);

        repeat (2) @(negedge clk);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL leftover_writes: got %0d pending, want 0", wq.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
